// File: rtl/bsg_rom_param_streamer.sv
// bsg_rom_param_streamer: streams runs of consecutive entries from a constant
// parameter ROM over a valid/yumi interface. Runs wrap modulo els_p.
// Optional loop mode enabled by defining BSG_ROM_PARAM_STREAMER_LOOP_EN.
// width_p, els_p and data_p carry minimal defaults only so the module can
// be elaborated stand-alone; every instance is expected to override them.
module bsg_rom_param_streamer #(
    parameter int width_p = 1,
    parameter int els_p   = 1,
    parameter     data_p  = 1'b0,
    localparam int lg_els_lp = (els_p <= 1) ? 1 : $clog2(els_p),
    localparam int lg_cnt_lp = ((els_p + 1 <= 1) ? 1 : $clog2(els_p + 1)) + 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_v_i,
    input  logic [lg_els_lp-1:0] start_base_i,
    input  logic [lg_cnt_lp-1:0] start_count_i,
`ifdef BSG_ROM_PARAM_STREAMER_LOOP_EN
    input  logic                 loop_i,
    input  logic                 stop_i,
`endif
    output logic                 start_ready_o,
    output logic                 v_o,
    output logic [width_p-1:0]   data_o,
    output logic [lg_els_lp-1:0] addr_o,
    output logic                 last_o,
    input  logic                 yumi_i
);

    localparam logic [width_p*els_p-1:0] data_lp = data_p;

    typedef enum logic {IDLE, STREAM} state_e;

    state_e               r_state;
    logic                 r_v;
    logic                 r_last;
    logic [width_p-1:0]   r_data;
    logic [lg_els_lp-1:0] r_addr;
    logic [lg_cnt_lp-1:0] r_rem;    // entries still to come after the current one

    logic                 w_start_ready;
    logic                 w_last;
    logic [lg_els_lp-1:0] w_addr_nxt;

    function automatic logic [width_p-1:0] rom_entry(input logic [lg_els_lp-1:0] idx);
        return data_lp[idx*width_p +: width_p];
    endfunction

    assign w_start_ready = (r_state == IDLE);
    // Wrap at els_p, not at the power of two above it
    assign w_addr_nxt = (r_addr == lg_els_lp'(els_p - 1)) ? '0 : r_addr + 1'b1;

`ifdef BSG_ROM_PARAM_STREAMER_LOOP_EN
    logic                 r_loop;
    logic [lg_els_lp-1:0] r_base;
    logic [lg_cnt_lp-1:0] r_count;
    // stop_i forces the end of the run on whatever entry is presented
    assign w_last = r_last | (r_loop & stop_i);
`else
    assign w_last = r_last;
`endif

    // Sequencer: accepts commands in IDLE, walks the ROM in STREAM
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_v     <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_rem   <= '0;
`ifdef BSG_ROM_PARAM_STREAMER_LOOP_EN
            r_loop  <= 1'b0;
            r_base  <= '0;
            r_count <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    // zero-length commands are consumed without leaving IDLE
                    if (start_v_i && (start_count_i != '0)) begin
                        r_state <= STREAM;
                        r_v     <= 1'b1;
                        r_addr  <= start_base_i;
                        r_data  <= rom_entry(start_base_i);
                        r_rem   <= start_count_i - lg_cnt_lp'(1);
                        r_last  <= (start_count_i == lg_cnt_lp'(1));
`ifdef BSG_ROM_PARAM_STREAMER_LOOP_EN
                        r_loop  <= loop_i;
                        r_base  <= start_base_i;
                        r_count <= start_count_i;
`endif
                    end
                end
                STREAM: begin
                    if (yumi_i) begin
                        if (!w_last) begin
                            r_addr <= w_addr_nxt;
                            r_data <= rom_entry(w_addr_nxt);
                            r_rem  <= r_rem - lg_cnt_lp'(1);
                            r_last <= (r_rem == lg_cnt_lp'(1));
                        end
`ifdef BSG_ROM_PARAM_STREAMER_LOOP_EN
                        else if (r_loop && !stop_i) begin
                            // natural end of a pass: restart from base, no bubble
                            r_addr <= r_base;
                            r_data <= rom_entry(r_base);
                            r_rem  <= r_count - lg_cnt_lp'(1);
                            r_last <= (r_count == lg_cnt_lp'(1));
                        end
`endif
                        else begin
                            r_state <= IDLE;
                            r_v     <= 1'b0;
                            r_last  <= 1'b0;
`ifdef BSG_ROM_PARAM_STREAMER_LOOP_EN
                            r_loop  <= 1'b0;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Simulation-only protocol and parameter sanity checks
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !r_v));
            assert (!(start_v_i && w_start_ready && (int'(start_base_i) >= els_p)));
        end
        assert ($bits(data_p) == width_p * els_p);
    end

    assign start_ready_o = w_start_ready;
    assign v_o           = r_v;
    assign data_o        = r_data;
    assign addr_o        = r_addr;
    assign last_o        = w_last;

endmodule

// File: doc/bsg_rom_param_streamer.md
Name: bsg_rom_param_streamer

Overview:
- Parametrised ROM sequencer. A constant bit-vector parameter holds els_p entries of width_p bits.
- On a start command, the block streams a run of consecutive entries over a valid/yumi interface. Runs wrap modulo els_p.
- Used for boot/config tables, init sequences and test-pattern sources, where a plain combinational ROM lookup would need an external address counter and handshake logic.
- Output data is registered, so there is no combinational path from the ROM to the consumer.

Parameters:
- width_p, no default (required), entry width in bits, >=1.
- els_p, no default (required), number of entries, >=1. Does not need to be a power of two.
- data_p, no default (required), width_p*els_p bits. Entry i occupies bits [i*width_p +: width_p].
- lg_els_lp, derived localparam: `BSG_SAFE_CLOG2(els_p).
- lg_cnt_lp, derived localparam: `BSG_SAFE_CLOG2(els_p+1)+1, the run-length counter width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- start_v_i  in  1  start command valid.
- start_base_i  in  lg_els_lp  first entry index. Must be < els_p; out-of-range values are undefined (an assertion flags them in simulation).
- start_count_i  in  lg_cnt_lp  number of entries to stream. 0 is legal.
- start_ready_o  out  1  block idle and able to accept a command.
- v_o  out  1  data_o/addr_o/last_o are valid.
- data_o  out  width_p  current entry.
- addr_o  out  lg_els_lp  index of current entry.
- last_o  out  1  current entry is the final one of the run.
- yumi_i  in  1  consumer takes the current entry. Only legal while v_o=1.

Behaviour:
- Fixed interface decision: one clock; reset is synchronous and active-high; ports are clk_i and reset_i.
- Reset values: state=IDLE, v_o=0, last_o=0, data_o=0, addr_o=0, start_ready_o=1 from the first cycle after reset.
- States: IDLE and STREAM.
- start_ready_o = (state==IDLE). A command is accepted on start_v_i & start_ready_o.
- Accept in IDLE with count=0: command is consumed; state stays IDLE; v_o stays 0.
- Accept in IDLE with count>=1:
  - Next cycle: state=STREAM, v_o=1, addr_o=base, data_o=entry[base], last_o=(count==1).
  - Internal remaining counter = count-1.
  - Latency from accept to first v_o is exactly 1 cycle.
- In STREAM with yumi_i=1 and last_o=0:
  - Next cycle presents entry at addr_o+1, wrapping to 0 when addr_o==els_p-1 (true modulo els_p, not modulo 2^lg_els_lp).
  - Remaining counter decrements; last_o=1 when remaining reaches 0.
  - Throughput is one entry per cycle with no bubbles.
- In STREAM with yumi_i=0: all outputs hold stable (valid must not drop, data must not change).
- In STREAM with yumi_i=1 and last_o=1: next cycle v_o=0, last_o=0, state=IDLE, start_ready_o=1.
  - No same-cycle restart: a new command needs at least one idle cycle, so back-to-back runs have a 1-cycle gap.
- Runs may exceed els_p (count up to 2^lg_cnt_lp-1). The address wraps repeatedly.
- data_o and addr_o hold their last values while idle; they are only meaningful when v_o=1.
- reset_i asserted mid-run aborts the run. The next cycle shows the reset values, and no partial state persists.
- Simulation assertions:
  - yumi_i & ~v_o is an error.
  - start_base_i >= els_p on an accepted command is an error.
  - $bits(data_p) != width_p*els_p is an error.
- els_p==1: addr_o is always 0; every run repeats entry 0.

Optional Feature:
- Macro: BSG_ROM_PARAM_STREAMER_LOOP_EN.
- When defined, two ports are added:
  - loop_i  in  1  sampled with the start command.
  - stop_i  in  1  level input, honoured only in loop mode.
- Accepting a command with loop_i=1 and count>=1 enters loop mode.
  - After the final entry of the run is taken, the block restarts at base with the original count, with no bubble. last_o still flags the end of each pass.
  - While stop_i=1, the presented entry has last_o forced to 1, and the run ends when that entry is taken.
  - If stop_i falls before the yumi, last_o reverts to its natural value.
- When the macro is not defined: the loop_i/stop_i ports do not exist; behaviour is exactly single-shot as above; no loop logic is synthesised.

Test Plan:
- Setup for all scenarios: width_p=8, els_p=6, entry i = 8'h10+i.
- Reset then idle: hold reset_i 2 cycles -> v_o=0, start_ready_o=1 on the first post-reset cycle.
- Basic run: start base=1, count=3, yumi_i tied 1 -> cycles +1..+3 show addr 1,2,3 and data 11,12,13; last_o=1 only on 13; start_ready_o=1 at +4.
- Wrap and backpressure: base=4, count=8, yumi_i toggled 1,0,1,... -> sequence 14,15,10,11,12,13,14,15 (addr wraps 5->0, never 6 or 7); outputs stable on every yumi=0 cycle; last_o on the final 15.
- Zero count and back-to-back: count=0 -> no v_o, start_ready_o stays 1. Then count=1 base=5 -> single 15 with last_o=1. Start held high -> second run's first beat appears exactly 2 cycles after the first run's yumi.
- Reset mid-run: base=0 count=6, reset after 2 beats -> next cycle v_o=0. New run base=2 count=2 -> 12,13 correct.
- Loop mode (macro on): base=3 count=2 loop_i=1 -> 13,14,13,14,... with last_o on each 14. Raise stop_i while 13 is presented -> 13 shows last_o=1, then idle.
